// File: rtl/key_pkg.sv
// Shared types and constants for the pushbutton scanner.
package key_pkg;

   localparam int NUM_KEYS = 4;
   localparam int KEY_W    = $clog2(NUM_KEYS);

   typedef logic [KEY_W-1:0] key_idx_t;

   // Per-key debounce state; encodings are fixed so they can be probed.
   typedef enum logic [1:0] {
      UP     = 2'd0,
      CHK_DN = 2'd1,
      DOWN   = 2'd2,
      CHK_UP = 2'd3
   } key_state_e;

   // Lowest set index of a key vector; returns 0 for an all-zero vector.
   function automatic key_idx_t lowest_idx(input logic [NUM_KEYS-1:0] v);
      key_idx_t idx;
      idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = key_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-FF synchroniser, tick-driven debounce FSM,
// registered level and one-cycle press/release strobes.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int STABLE_CNT = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic key_n_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int CNT_W = (STABLE_CNT > 2) ? $clog2(STABLE_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic [1:0]       sync_q;
   key_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             press_q;
   logic             release_q;
   logic             s;

   // Synchronised pin, inverted so that 1 means the button is held.
   assign s = ~sync_q[1];

   // Synchroniser, debounce FSM and registered outputs in one process.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sync flops reset to the released level so a reset never looks like a press.
         sync_q    <= 2'b11;
         state_q   <= UP;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples pre-edge values.
         sync_q    <= {sync_q[0], key_n_i};
         press_q   <= 1'b0;
         release_q <= 1'b0;
         if (tick_i) begin
            unique case (state_q)
               UP: begin
                  if (s) begin
                     state_q <= CHK_DN;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               CHK_DN: begin
                  if (!s) begin
                     state_q <= UP;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= DOWN;
                     cnt_q   <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               DOWN: begin
                  if (!s) begin
                     state_q <= CHK_UP;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               CHK_UP: begin
                  if (s) begin
                     state_q <= DOWN;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q   <= UP;
                     cnt_q     <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= UP;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/key_scan.sv
// Pushbutton scanner: shared debounce prescaler, one debounce channel per
// key and a registered lowest-index press encoder.
module key_scan
   import key_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [KEY_W-1:0]    key_code,
   output logic                key_valid
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic          tick;
   key_idx_t      key_code_q;
   logic          key_valid_q;

   // Prescaler next state: count 0..TICK_DIV-1 and wrap; tick on the last count.
   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   // Prescaler register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) presc_q <= '0;
      else     presc_q <= presc_d;
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .STABLE_CNT (STABLE_CNT)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .tick_i    (tick),
         .key_n_i   (key_in[i]),
         .level_o   (key_level[i]),
         .press_o   (key_press[i]),
         .release_o (key_release[i])
      );
   end

   // Encoder: latch the lowest pressed index and strobe valid once per press cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
      end else begin
         key_valid_q <= |key_press;
         if (|key_press) key_code_q <= lowest_idx(key_press);
      end
   end

   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_key_scan.sv
// Scoreboard bench for key_scan with TICK_DIV = 4, STABLE_CNT = 3.
module tb_key_scan;

   localparam int TD = 4;
   localparam int SC = 3;

   typedef struct {
      logic [3:0] press;
      logic [3:0] rel;
      logic       valid;
      logic [1:0] code;
      logic [3:0] level;
      int         cyc;
   } ev_t;

   logic       clk;
   logic       rst;
   logic [3:0] key_in;
   logic [3:0] key_level;
   logic [3:0] key_press;
   logic [3:0] key_release;
   logic [1:0] key_code;
   logic       key_valid;

   int  n_tests;
   int  n_fail;
   int  cyc;
   ev_t exp_q[$];

   key_scan #(
      .TICK_DIV   (TD),
      .STABLE_CNT (SC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_code    (key_code),
      .key_valid   (key_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge count since the last reset release; edge k carries a tick when k % TD == 0.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc = 0;
      else     cyc = cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Cycle at which a strobe appears for a pin change driven when the count was c0:
   // two sync edges, then SC tick edges at multiples of TD.
   function automatic int strobe_cyc(input int c0);
      int f;
      f = c0 + 3;
      while (f % TD != 0) f++;
      return f + (SC - 1) * TD;
   endfunction

   function automatic ev_t mk(input logic [3:0] p, input logic [3:0] r, input logic v,
                              input logic [1:0] c, input logic [3:0] l, input int t);
      ev_t e;
      e.press = p; e.rel = r; e.valid = v; e.code = c; e.level = l; e.cyc = t;
      return e;
   endfunction

   function automatic logic [31:0] pack_out(input logic [3:0] p, input logic [3:0] r,
                                            input logic v, input logic [1:0] c, input logic [3:0] l);
      return {12'd0, p, r, 3'd0, v, 2'd0, c, l};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every cycle with any strobe must match the next expected event.
   always @(negedge clk) begin
      if ((key_press | key_release) != 4'd0 || key_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: press=%b release=%b valid=%b code=%0d at cyc %0d, none expected",
                     key_press, key_release, key_valid, key_code, cyc);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("event_cycle", cyc, e.cyc);
            check("event_outputs {press,rel,valid,code,level}",
                  pack_out(key_press, key_release, key_valid, key_code, key_level),
                  pack_out(e.press, e.rel, e.valid, e.code, e.level));
         end
      end
   end

   initial begin
      int c0;
      int p;
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      key_in  = 4'b1111;

      // Reset state.
      step(5);
      check("reset_outputs", pack_out(key_press, key_release, key_valid, key_code, key_level), 32'd0);
      rst = 1'b0;

      // Idle with all keys released.
      step(100);
      check("idle_level", key_level, 4'b0000);
      check("idle_code", key_code, 2'd0);

      // Bounce on key 1: 6 clk low / 6 clk high, never three ticks in a row.
      for (int r = 0; r < 5; r++) begin
         key_in = 4'b1101;
         step(6);
         key_in = 4'b1111;
         step(6);
      end
      step(8);
      check("bounce_level", key_level, 4'b0000);
      check("bounce_code", key_code, 2'd0);

      // Press and hold key 2.
      key_in = 4'b1011;
      c0 = cyc;
      p = strobe_cyc(c0);
      exp_q.push_back(mk(4'b0100, 4'b0000, 1'b0, 2'd0, 4'b0100, p));
      exp_q.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd2, 4'b0100, p + 1));
      step(20);
      check("press2_level", key_level, 4'b0100);
      check("press2_code", key_code, 2'd2);

      // Release key 2: code holds, no valid.
      key_in = 4'b1111;
      c0 = cyc;
      p = strobe_cyc(c0);
      exp_q.push_back(mk(4'b0000, 4'b0100, 1'b0, 2'd2, 4'b0000, p));
      step(20);
      check("release2_level", key_level, 4'b0000);
      check("release2_code", key_code, 2'd2);

      // Keys 3 and 0 together: one press cycle, one valid with the lower index.
      key_in = 4'b0110;
      c0 = cyc;
      p = strobe_cyc(c0);
      exp_q.push_back(mk(4'b1001, 4'b0000, 1'b0, 2'd2, 4'b1001, p));
      exp_q.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd0, 4'b1001, p + 1));
      step(20);
      check("dual_level", key_level, 4'b1001);
      check("dual_code", key_code, 2'd0);

      key_in = 4'b1111;
      c0 = cyc;
      p = strobe_cyc(c0);
      exp_q.push_back(mk(4'b0000, 4'b1001, 1'b0, 2'd0, 4'b0000, p));
      step(20);
      check("dual_release_level", key_level, 4'b0000);

      // Key 1 held through a reset taken mid-qualification.
      key_in = 4'b1101;
      step(6);
      rst = 1'b1;
      step(3);
      check("midreset_outputs", pack_out(key_press, key_release, key_valid, key_code, key_level), 32'd0);
      rst = 1'b0;
      c0 = cyc;
      p = strobe_cyc(c0);
      exp_q.push_back(mk(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0010, p));
      exp_q.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd1, 4'b0010, p + 1));
      step(20);
      check("postreset_level", key_level, 4'b0010);
      check("postreset_code", key_code, 2'd1);

      key_in = 4'b1111;
      c0 = cyc;
      p = strobe_cyc(c0);
      exp_q.push_back(mk(4'b0000, 4'b0010, 1'b0, 2'd1, 4'b0000, p));
      step(20);
      check("final_level", key_level, 4'b0000);

      // Anything still queued was never produced by the DUT.
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missing_event: expected press=%b release=%b valid=%b at cyc %0d, not seen",
                  e.press, e.rel, e.valid, e.cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
- Input-side counterpart to the LED output path: reads the board's 4 active-low pushbuttons and debounces each one.
- Reports per-key debounced levels, one-cycle press and release strobes, and an encoded key index with a valid strobe.
- Sits between the raw button pins and the control logic that drives the LED pattern.

Parameters:
- TICK_DIV, 50000: clk cycles per debounce sample tick; must be >= 2.
- STABLE_CNT, 20: consecutive ticks at the new level required to accept a transition; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  4  raw pushbuttons, active-low (0 = pressed), asynchronous to clk.
- key_level  output  4  debounced state, active-high (1 = held).
- key_press  output  4  one-clk strobe per key on an accepted press.
- key_release  output  4  one-clk strobe per key on an accepted release.
- key_code  output  2  index of the most recently pressed key.
- key_valid  output  1  one-clk strobe; key_code was updated this cycle.

Behaviour:
- Reset is asynchronous and active-high: one clock, no other reset.
- Reset values:
  - sync flops = 4'b1111 (released).
  - key_level, key_press, key_release, key_code, key_valid = 0.
  - prescaler = 0; all channels in UP with cnt = 0.
- Synchroniser: 2-FF per bit, then inverted; s[i] = 1 means pressed.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 in the cycle the count equals TICK_DIV-1.
  - The first tick after reset release occurs in cycle TICK_DIV.
- Per-key FSM, 4 states, evaluated only when tick = 1 (state holds otherwise):
  - UP: s = 1 -> CHK_DN, cnt = 1; else stay.
  - CHK_DN: s = 0 -> UP, cnt = 0 (bounce rejected); s = 1 and cnt == STABLE_CNT-1 -> DOWN, key_press[i] = 1 next cycle; else cnt++.
  - DOWN: s = 0 -> CHK_UP, cnt = 1; else stay.
  - CHK_UP: s = 1 -> DOWN, cnt = 0; s = 0 and cnt == STABLE_CNT-1 -> UP, key_release[i] = 1 next cycle; else cnt++.
- key_level[i] = 1 in DOWN and CHK_UP, 0 in UP and CHK_DN. Registered, changes in the same cycle as the matching strobe.
- Strobes are exactly one clk wide. A key cannot produce press and release in the same cycle.
- cnt width = clog2(STABLE_CNT); it never exceeds STABLE_CNT-1.
- Encoder, registered:
  - When any key_press bit is set, key_code = lowest set index and key_valid = 1 for one cycle.
  - Otherwise key_code holds and key_valid = 0.
  - Simultaneous presses on one tick give a single key_valid carrying the lowest index; every bit still appears in key_press.
  - Releases never touch key_code or key_valid.
- Press latency, pin edge to key_press: 2 sync cycles + STABLE_CNT ticks + 1 register cycle. This falls between (STABLE_CNT-1)*TICK_DIV+3 and STABLE_CNT*TICK_DIV+3 clk, depending on tick phase.
- Reset mid-debounce or with a key held:
  - All channels return to UP.
  - A key still held after release of rst produces a fresh press after full qualification.
  - No release strobe is emitted for the aborted state.
- Keys are fully independent; a glitch on one key never disturbs another key's cnt.

Decomposition:
- Shared package key_pkg:
  - per-key state enum: UP = 2'd0, CHK_DN = 2'd1, DOWN = 2'd2, CHK_UP = 2'd3.
  - NUM_KEYS = 4.
- Sub-module key_debounce_ch holds the sync flops, FSM, cnt, level and strobes for one key, instantiated NUM_KEYS times.
- key_scan owns the shared prescaler and the priority encoder.

Test Plan (TICK_DIV = 4, STABLE_CNT = 3):
1. Hold reset, then release with key_in = 1111 for 100 clk -> all outputs stay 0; tick first pulses at cycle 4, then every 4 cycles.
2. key_in[2] goes to 0 and is held -> exactly one key_press = 0100 between 11 and 15 clk later; key_level = 0100; key_code = 2 with key_valid pulsing once.
3. key_in[1] low for 6 clk (at most 2 ticks), then high, repeated 5 times -> no key_press, no key_valid, key_level stays 0000.
4. From scenario 2, key_in[2] returns to 1 -> one key_release = 0100 within 11-15 clk; key_level = 0000; key_code remains 2 with no key_valid.
5. key_in[3] and key_in[0] fall in the same cycle -> key_press = 1001 in one cycle; a single key_valid with key_code = 0.
6. Press key 1, assert rst during CHK_DN, then deassert with the key still held -> no strobes during reset; after 11-15 clk one key_press = 0010 and key_code = 1.
